// File: rtl/kolibri_io_pkg.sv
// rtl/kolibri_io_pkg.sv - Kolibri $FExx I/O register map, SPI status bits and engine state encoding
package kolibri_io_pkg;

    localparam logic [7:0] ADDR_SPI_DATA = 8'h32;
    localparam logic [7:0] ADDR_SPI_CTRL = 8'h33;

    localparam int STAT_BUSY = 7;
    localparam int STAT_DONE = 6;
    localparam int STAT_OVR  = 5;
    localparam int CTRL_FAST = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } spi_state_e;

endpackage

// File: rtl/spi_halfper_cnt.sv
// rtl/spi_halfper_cnt.sv - SCLK half-period down-counter with single-cycle expiry pulse
module spi_halfper_cnt #(
    parameter int DIV_SLOW = 60,
    parameter int DIV_FAST = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_fast,
    input  logic i_restart,
    input  logic i_en,
    output logic o_expire
);

    localparam int CW = $clog2(DIV_SLOW + 1);
    localparam logic [CW-1:0] LD_SLOW = CW'(DIV_SLOW - 1);
    localparam logic [CW-1:0] LD_FAST = CW'(DIV_FAST - 1);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_load;

    assign w_load = i_fast ? LD_FAST : LD_SLOW;

    // Expiry is the last cycle of a half-period; the counter auto-reloads so
    // consecutive half-periods run back to back without a gap cycle.
    assign o_expire = i_en && !i_restart && (r_cnt == '0);

    // Load on restart, then count down and reload on expiry while enabled
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_restart) begin
            r_cnt <= w_load;
        end else if (i_en) begin
            if (r_cnt == '0) begin
                r_cnt <= w_load;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_byte_engine.sv
// rtl/spi_byte_engine.sv - SPI mode-0 byte shifter behind the $FE32/$FE33 registers
module spi_byte_engine
    import kolibri_io_pkg::*;
#(
    parameter int DIV_SLOW = 60,
    parameter int DIV_FAST = 2
) (
    input  logic       MHZ48,
    input  logic       RES,
    input  logic       WE,
    input  logic       RE,
    input  logic       REG,
    input  logic [7:0] DI,
    output logic [7:0] DO,
    output logic       SCLK,
    output logic       MOSI,
    input  logic       MISO,
    output logic       BUSY
);

    spi_state_e r_state;
    spi_state_e w_state_nxt;

    // r_sr holds the untransmitted bits in its upper end and the received bits
    // in its lower end; bit 7 of the written byte goes straight to MOSI.
    logic [6:0] r_sr;
    logic [7:0] r_rx;
    logic [2:0] r_bit;
    logic       r_sclk;
    logic       r_mosi;
    logic       r_done;
    logic       r_ovr;
    logic       r_fast;
    logic       r_div_fast;

    logic       w_data_wr;
    logic       w_ctrl_wr;
    logic       w_data_rd;
    logic       w_start;
    logic       w_expire;
    logic       w_last;
    logic       w_finish;
    logic       w_fast_sel;
    logic [7:0] w_stat;

    assign w_data_wr  = WE && !REG;
    assign w_ctrl_wr  = WE && REG;
    assign w_data_rd  = RE && !REG;
    assign w_start    = w_data_wr && (r_state == ST_IDLE);
    assign w_last     = (r_bit == 3'd7);
    assign w_finish   = (r_state == ST_HIGH) && w_expire && w_last;
    // The divider for the first half-period must see the FAST value being latched now
    assign w_fast_sel = w_start ? r_fast : r_div_fast;

    assign BUSY = (r_state != ST_IDLE);
    assign SCLK = r_sclk;
    assign MOSI = r_mosi;

    spi_halfper_cnt #(
        .DIV_SLOW (DIV_SLOW),
        .DIV_FAST (DIV_FAST)
    ) u_halfper (
        .i_clk     (MHZ48),
        .i_rst     (RES),
        .i_fast    (w_fast_sel),
        .i_restart (w_start),
        .i_en      (BUSY),
        .o_expire  (w_expire)
    );

    // State register
    always_ff @(posedge MHZ48 or posedge RES) begin
        if (RES) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: IDLE -> LOW on accepted write, LOW <-> HIGH on each expiry, HIGH -> IDLE after bit 0
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_start)  w_state_nxt = ST_LOW;
            ST_LOW:  if (w_expire) w_state_nxt = ST_HIGH;
            ST_HIGH: if (w_expire) w_state_nxt = w_last ? ST_IDLE : ST_LOW;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Shift datapath, SCLK/MOSI pins, RX buffer and divider latch
    always_ff @(posedge MHZ48 or posedge RES) begin
        if (RES) begin
            r_sr       <= '0;
            r_rx       <= 8'h00;
            r_bit      <= 3'd0;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b1;
            r_div_fast <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_sr       <= DI[6:0];
                        r_div_fast <= r_fast;
                        r_mosi     <= DI[7];
                        r_sclk     <= 1'b0;
                        r_bit      <= 3'd0;
                    end
                end
                ST_LOW: begin
                    if (w_expire) begin
                        r_sclk <= 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (w_expire) begin
                        r_sr   <= {r_sr[5:0], MISO};
                        r_sclk <= 1'b0;
                        r_bit  <= r_bit + 3'd1;
                        if (w_last) begin
                            r_rx   <= {r_sr, MISO};
                            r_mosi <= 1'b1;
                        end else begin
                            r_mosi <= r_sr[6];
                        end
                    end
                end
                default: begin
                    r_sclk <= 1'b0;
                    r_mosi <= 1'b1;
                end
            endcase
        end
    end

    // Control and sticky flags; a set in the same cycle as a clearing read wins
    always_ff @(posedge MHZ48 or posedge RES) begin
        if (RES) begin
            r_fast <= 1'b0;
            r_done <= 1'b0;
            r_ovr  <= 1'b0;
        end else begin
            if (w_ctrl_wr) begin
                r_fast <= DI[CTRL_FAST];
            end
            if (w_finish) begin
                r_done <= 1'b1;
            end else if (w_data_rd) begin
                r_done <= 1'b0;
            end
            if (w_data_wr && BUSY) begin
                r_ovr <= 1'b1;
            end else if (w_data_rd) begin
                r_ovr <= 1'b0;
            end
        end
    end

    // Read mux: registers are pre-update, so a read in a write cycle sees old values
    always_comb begin
        w_stat            = 8'h00;
        w_stat[STAT_BUSY] = BUSY;
        w_stat[STAT_DONE] = r_done;
        w_stat[STAT_OVR]  = r_ovr;
        w_stat[CTRL_FAST] = r_fast;
        DO                = REG ? w_stat : r_rx;
    end

endmodule

// File: doc/spi_byte_engine.md
# spi_byte_engine

Hardware SPI mode-0 byte shifter for the Kolibri CPLD, replacing the bit-banged SCLK/MOSI path driven through $FE2E/$FE2F/$FE31. It sits downstream of the $FExx I/O address decode. The decoder hands it single-cycle, MHZ48-synchronous read/write strobes for $FE32 (data) and $FE33 (control/status). The engine drives SCLK/MOSI and samples MISO toward whichever SD/SPI device the existing $FE30 chip-select latch has enabled.

## Interface
Parameters:
- DIV_SLOW, 60, half-period of SCLK in MHZ48 cycles for slow mode (400 kHz, SD init)
- DIV_FAST, 2, half-period in fast mode (12 MHz); legal range 1..DIV_SLOW

Ports:
- MHZ48  in  1  master clock; all state on rising edge
- RES  in  1  asynchronous, active-high reset
- WE  in  1  one-cycle write strobe from I/O decode, synchronous to MHZ48
- RE  in  1  one-cycle read strobe, synchronous to MHZ48
- REG  in  1  register select: 0 = DATA ($FE32), 1 = CTRL/STAT ($FE33)
- DI  in  8  CPU write data, valid with WE
- DO  out  8  read data, combinational from REG
- SCLK  out  1  SPI clock, idle low
- MOSI  out  1  SPI data out, idle high
- MISO  in  1  SPI data in
- BUSY  out  1  transfer in progress

## Operation
- States: IDLE, LOW (SCLK=0 half), HIGH (SCLK=1 half). Bit counter 0..7; half-period counter sized for DIV_SLOW.
- CTRL write: bit0 FAST; bits 7..1 are ignored. Reading CTRL/STAT returns {BUSY, DONE, OVR, 4'b0, FAST}.
- DATA write in IDLE:
  - Latch DI into the shift register and latch FAST into the active divider.
  - Drive MOSI = DI[7] and enter LOW.
- LOW expiry (DIV cycles): SCLK goes 1, enter HIGH.
- HIGH expiry:
  - Sample MISO into shift-register LSB while shifting left.
  - SCLK goes 0 and MOSI takes the next bit.
  - After the 8th HIGH, go to IDLE, set DONE, copy the shift register to RX, and drive MOSI to 1.
- DATA write while BUSY: ignored, and the sticky OVR flag is set.
- CTRL write while BUSY: FAST updates immediately but takes effect only at the next transfer start.
- DATA read returns RX and clears DONE and OVR. A DATA read while BUSY returns the previous RX and clears the flags.
- WE and RE asserted in the same cycle: the write is processed and the read returns pre-write values. If that read is a DATA read that clears flags, an OVR set by the same write wins.
- Reset, including mid-transfer: the transfer aborts immediately and no RX update occurs.
- Reset values: SCLK=0, MOSI=1, BUSY=0, DONE=0, OVR=0, FAST=0, RX=8'h00, state IDLE, DO follows REG (8'h00 for both).

## Timing
- The WE cycle is cycle 0. Registered outputs change at the cycle-1 edge: BUSY=1, MOSI=bit7, SCLK=0.
- Rising SCLK edges occur at cycles 1+(2k+1)·DIV; falling edges at 1+(2k+2)·DIV, for k=0..7.
- MISO bit (7-k) is sampled at the 1+(2k+2)·DIV edge, i.e. the end of the high phase, for maximum slave setup.
- Final falling edge at cycle 1+16·DIV: BUSY=0, DONE=1, RX valid, MOSI=1, all on the same edge.
- BUSY is therefore high for exactly 16·DIV cycles. A new DATA write is accepted in the first cycle BUSY reads 0.
- DIV=1 gives SCLK = MHZ48/2. MISO is not synchronised; the board guarantees slave output timing against the sampling edge.

## Structure
- Shared package kolibri_io_pkg:
  - register offsets ADDR_SPI_DATA=8'h32 and ADDR_SPI_CTRL=8'h33;
  - status bit positions STAT_BUSY=7, STAT_DONE=6, STAT_OVR=5, CTRL_FAST=0;
  - state encoding for IDLE/LOW/HIGH.
- One sub-module, spi_halfper_cnt: loadable down-counter. Inputs are DIV select and restart; output is a single-cycle expiry pulse.
- The top holds the FSM, shift register, RX, and flags.

## Test plan
- Slow loopback (MISO tied to MOSI), write $FE32=8'hA5 -> 8 SCLK pulses of 60+60 cycles; BUSY high 960 cycles; DATA read=8'hA5, DONE=1 then 0 after the read.
- FAST=1, slave model returns 8'h3C while 8'hFF is written -> MOSI stays 1, BUSY high 32 cycles, RX=8'h3C, SCLK period 4 cycles.
- Second DATA write (8'h11) while BUSY -> OVR=1, current byte unaffected, MOSI never shows 8'h11. DATA read clears OVR.
- FAST written mid-transfer -> current transfer keeps slow timing; the next transfer uses 2-cycle half-periods.
- RES pulsed at the 3rd SCLK high -> SCLK=0, MOSI=1, BUSY=0, RX=8'h00, STAT=8'h00 on the same edge; a following transfer completes normally.
- Back-to-back: write in the cycle after BUSY falls -> accepted; MOSI=bit7 one cycle later with no idle gap violation.
